// File: rtl/ram_banked_if.sv
// Bus bundle for ram_banked: write/read/clear requests in, registered read data and status out.
interface ram_banked_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 9
);
    logic [WIDTH-1:0]  in;
    logic [ADDR_W-1:0] addr;
    logic              load;
    logic              rd_en;
    logic              clr;
    logic [WIDTH-1:0]  out;
    logic              out_valid;
    logic              busy;
    logic              out_err;

    modport master (
        output in, addr, load, rd_en, clr,
        input  out, out_valid, busy, out_err
    );

    modport slave (
        input  in, addr, load, rd_en, clr,
        output out, out_valid, busy, out_err
    );
endinterface

// File: rtl/ram_banked.sv
// Banked word RAM with registered read, valid flag and an auto-clear sequencer (reset / clr).
// Optional per-word even parity with read-side error flag when RAM_PARITY_EN is defined.
module ram_banked #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 512,
    parameter int BANKS = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    ram_banked_if.slave  bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int ROWS   = DEPTH / BANKS;
    localparam int BANK_W = $clog2(BANKS);
    localparam int ROW_W  = ADDR_W - BANK_W;
`ifdef RAM_PARITY_EN
    localparam int MW = WIDTH + 1;
`else
    localparam int MW = WIDTH;
`endif

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t             state_q, state_d;
    logic [ROW_W-1:0]   row_cnt_q, row_cnt_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               out_valid_q, out_valid_d;
    logic               out_err_q, out_err_d;

    logic [MW-1:0]      mem [BANKS][ROWS];

    logic [BANK_W-1:0]  bank_sel;
    logic [ROW_W-1:0]   row_sel;
    logic [MW-1:0]      rd_word;
    logic               busy;
    logic               wr_fire;
    logic               rd_fire;
    logic [BANKS-1:0]   bank_we;
    logic [ROW_W-1:0]   wr_row;
    logic [MW-1:0]      wr_word;

    assign bank_sel = bus.addr[ADDR_W-1 -: BANK_W];
    assign row_sel  = bus.addr[ROW_W-1:0];
    assign rd_word  = mem[bank_sel][row_sel];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CLEAR;
            row_cnt_q   <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            out_err_q   <= out_err_d;
        end
    end

    // A running clear cannot be restarted; clr only matters from IDLE.
    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        case (state_q)
            CLEAR: begin
                row_cnt_d = row_cnt_q + 1'b1;
                if (row_cnt_q == ROW_W'(ROWS - 1)) state_d = IDLE;
            end
            default: begin
                if (bus.clr) begin
                    state_d   = CLEAR;
                    row_cnt_d = '0;
                end
            end
        endcase
    end

    always_comb begin
        busy    = (state_q == CLEAR);
        wr_fire = !busy && bus.load  && !bus.clr;
        rd_fire = !busy && bus.rd_en && !bus.clr;
        bank_we = '0;
        wr_row  = row_sel;
        wr_word = '0;
        if (busy) begin
            bank_we = '1;
            wr_row  = row_cnt_q;
        end else if (wr_fire) begin
            bank_we[bank_sel] = 1'b1;
        end
`ifdef RAM_PARITY_EN
        if (!busy) wr_word = {^bus.in, bus.in};
        out_err_d = rd_fire && (rd_word[WIDTH] != ^rd_word[WIDTH-1:0]);
`else
        if (!busy) wr_word = bus.in;
        out_err_d = 1'b0;
`endif
        out_d       = rd_fire ? rd_word[WIDTH-1:0] : out_q;
        out_valid_d = rd_fire;
    end

    // Array has no reset; the clear sequencer initialises it. Read above sees the pre-write word.
    always_ff @(posedge clk) begin
        for (int b = 0; b < BANKS; b++) begin
            if (bank_we[b]) mem[b][wr_row] <= wr_word;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy;
    assign bus.out_err   = out_err_q;
endmodule

// File: tb/tb_ram_banked.sv
// Randomised bench for ram_banked against a word-array model, plus directed literal checks.
module tb_ram_banked #(
    parameter int W = 16,
    parameter int D = 512,
    parameter int B = 32
);
    localparam int AW   = $clog2(D);
    localparam int ROWS = D / B;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_banked_if #(.WIDTH(W), .ADDR_W(AW)) bus();
    ram_banked #(.WIDTH(W), .DEPTH(D), .BANKS(B)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Model: plain word array, a clear countdown, and the last read result.
    logic [W-1:0] m_mem [D];
    bit           m_perr [D];
    int           m_clear = ROWS;
    logic [W-1:0] m_out   = '0;
    bit           m_valid = 1'b0;
    bit           m_err   = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_clear = ROWS;
            m_out   = '0;
            m_valid = 1'b0;
            m_err   = 1'b0;
        end else if (m_clear > 0) begin
            m_clear = m_clear - 1;
            m_valid = 1'b0;
            m_err   = 1'b0;
            if (m_clear == 0) begin
                for (int i = 0; i < D; i++) begin
                    m_mem[i]  = '0;
                    m_perr[i] = 1'b0;
                end
            end
        end else if (bus.clr) begin
            m_clear = ROWS;
            m_valid = 1'b0;
            m_err   = 1'b0;
        end else begin
            if (bus.rd_en) begin
                m_out   = m_mem[bus.addr];
                m_valid = 1'b1;
                m_err   = m_perr[bus.addr];
            end else begin
                m_valid = 1'b0;
                m_err   = 1'b0;
            end
            if (bus.load) begin
                m_mem[bus.addr]  = bus.in;
                m_perr[bus.addr] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp_busy",      bus.busy,      m_clear > 0);
            chk("cmp_out_valid", bus.out_valid, m_valid);
            chk("cmp_out",       bus.out,       m_out);
            chk("cmp_out_err",   bus.out_err,   m_err);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.load  = 1'b0;
        bus.rd_en = 1'b0;
        bus.clr   = 1'b0;
    endtask

    task automatic wr(input int a, input logic [W-1:0] d);
        bus.addr = AW'(a);
        bus.in   = d;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
    endtask

    task automatic rd(input string nm, input int a, input logic [W-1:0] exp);
        bus.addr  = AW'(a);
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        chk(nm, bus.out, exp);
        chk({nm, "_valid"}, bus.out_valid, 1'b1);
    endtask

    // Counts clock edges spent busy; optionally hammers accesses that must be ignored.
    task automatic wait_clear(input string nm, input bit poke);
        int n = 0;
        while (bus.busy === 1'b1 && n < 200) begin
            if (poke) begin
                bus.load  = 1'b1;
                bus.rd_en = 1'b1;
                bus.addr  = AW'(5);
                bus.in    = '1;
            end
            tick();
            n++;
        end
        idle();
        chk(nm, n, ROWS);
    endtask

    task automatic sweep_zero(input string nm);
        for (int i = 0; i < D; i++) begin
            bus.addr  = AW'(i);
            bus.rd_en = 1'b1;
            tick();
            chk($sformatf("%s[%0d]", nm, i), bus.out, 0);
            chk($sformatf("%s_valid[%0d]", nm, i), bus.out_valid, 1'b1);
        end
        bus.rd_en = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in   = '0;
        bus.addr = '0;
        idle();
        repeat (3) @(negedge clk);
        chk("rst_out",       bus.out,       0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy",      bus.busy,      1);
        chk("rst_out_err",   bus.out_err,   0);
        chk_en = 1'b1;
        rst_n  = 1'b1;
        wait_clear("reset_clear_len", 1'b0);
        sweep_zero("init_zero");

        wr(0, W'(16'hA5A5));
        wr(D - 1, W'(16'h1234));
        rd("rd_a5a5", 0, W'(16'hA5A5));
        rd("rd_1234", D - 1, W'(16'h1234));
        rd("rd_bank_iso", ROWS, '0);

        wr(85 % D, W'(16'h0001));
        bus.addr  = AW'(85 % D);
        bus.in    = W'(16'hBEEF);
        bus.load  = 1'b1;
        bus.rd_en = 1'b1;
        tick();
        idle();
        chk("rd_first_old", bus.out, W'(16'h0001));
        rd("rd_after_wr", 85 % D, W'(16'hBEEF));

        // clr together with an access: access dropped, clear starts
        bus.clr   = 1'b1;
        bus.load  = 1'b1;
        bus.rd_en = 1'b1;
        bus.addr  = AW'(7);
        bus.in    = W'(16'h7777);
        tick();
        idle();
        chk("clr_wins_valid", bus.out_valid, 0);
        chk("clr_busy", bus.busy, 1);
        wait_clear("clr_clear_len", 1'b1);
        rd("post_clr_0", 0, '0);
        rd("post_clr_85", 85 % D, '0);
        rd("post_clr_5", 5, '0);
        sweep_zero("clr_zero");

        // reset during a clear
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        repeat (7) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midclr_rst_out",   bus.out,       0);
        chk("midclr_rst_valid", bus.out_valid, 0);
        chk("midclr_rst_busy",  bus.busy,      1);
        @(negedge clk) rst_n = 1'b1;
        wait_clear("midclr_clear_len", 1'b0);

        // reset during a read
        wr(9, W'(16'hC3C3));
        bus.addr  = AW'(9);
        bus.rd_en = 1'b1;
        tick();
        chk("midrd_out", bus.out, W'(16'hC3C3));
        #2 rst_n = 1'b0;
        #1;
        chk("midrd_rst_out",   bus.out,       0);
        chk("midrd_rst_valid", bus.out_valid, 0);
        chk("midrd_rst_busy",  bus.busy,      1);
        bus.rd_en = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        wait_clear("midrd_clear_len", 1'b0);

`ifdef RAM_PARITY_EN
        wr(3, W'(16'h0003));
        dut.mem[0][3][W] = 1'b1;
        m_perr[3] = 1'b1;
        rd("par_bad_data", 3, W'(16'h0003));
        chk("par_bad_err", bus.out_err, 1);
        rd("par_clean_data", 0, '0);
        chk("par_clean_err", bus.out_err, 0);
`endif

        for (int k = 0; k < 3000; k++) begin
            bus.clr   = ($urandom_range(0, 149) == 0);
            bus.load  = $urandom_range(0, 1) != 0;
            bus.rd_en = $urandom_range(0, 2) != 0;
            bus.addr  = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7))
                                                     : AW'($urandom_range(0, D - 1));
            bus.in    = W'($urandom);
            tick();
        end
        idle();
        tick();
`ifndef RAM_PARITY_EN
        chk("no_parity_err", bus.out_err, 0);
`endif
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
